// File: rtl/dcache_wb_controller.sv
// Miss/writeback/flush sequencer between an N-way write-back dcache array and memory.
// Evicts dirty victims, fills blocks, counts hits, and on halt flushes dirty frames then dumps the hit count.
module dcache_wb_controller #(
  parameter int          WAYS     = 2,
  parameter int          SETS     = 8,
  parameter int          WORDS    = 2,
  parameter logic [31:0] HIT_ADDR = 32'h3100,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int SW = $clog2(SETS),
  localparam int OW = $clog2(WORDS),
  localparam int BW = (WORDS > 1) ? OW : 1,
  localparam int TW = 30 - SW - OW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          dmemREN,
  input  logic          dmemWEN,
  input  logic [31:0]   dmemaddr,
  input  logic          halt,
  input  logic          hit,
  input  logic [WW-1:0] victim_way,
  input  logic          frame_valid,
  input  logic          frame_dirty,
  input  logic [TW-1:0] frame_tag,
  input  logic [31:0]   rdata,
  input  logic          mem_ready,
  output logic [SW-1:0] cache_set,
  output logic [WW-1:0] cache_way,
  output logic [BW-1:0] cache_word,
  output logic          load_data,
  output logic          write_tag,
  output logic          set_valid,
  output logic          clear_dirty,
  output logic          dREN,
  output logic          dWEN,
  output logic [31:0]   daddr,
  output logic [31:0]   dstore,
  output logic          flushed,
  output logic [31:0]   hit_count
);

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB, COUNT, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic [WW-1:0] way_q, way_d;
  logic [TW-1:0] rtag_q, rtag_d;
  logic [TW-1:0] vtag_q, vtag_d;
  logic [BW-1:0] k_q, k_d;
  logic [SW-1:0] scan_set_q, scan_set_d;
  logic [WW-1:0] scan_way_q, scan_way_d;
  logic [31:0]   hit_count_q, hit_count_d;
  logic          filled_q, filled_d;

  logic [SW-1:0] req_set;
  logic [TW-1:0] req_tag;
  logic          last_word, last_way, last_set;
  logic          unused_addr;

  assign req_set     = dmemaddr[OW+2 +: SW];
  assign req_tag     = dmemaddr[OW+2+SW +: TW];
  assign unused_addr = ^dmemaddr[OW+1:0];
  assign last_word   = (k_q == BW'(WORDS - 1));
  assign last_way    = (scan_way_q == WW'(WAYS - 1));
  assign last_set    = (scan_set_q == SW'(SETS - 1));
  assign hit_count   = hit_count_q;

  function automatic logic [31:0] blk_addr(input logic [TW-1:0] tag, input logic [SW-1:0] set,
                                           input logic [BW-1:0] word);
    return (32'(tag) << (SW + OW + 2)) | (32'(set) << (OW + 2)) | (32'(word) << 2);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      set_q       <= '0;
      way_q       <= '0;
      rtag_q      <= '0;
      vtag_q      <= '0;
      k_q         <= '0;
      scan_set_q  <= '0;
      scan_way_q  <= '0;
      hit_count_q <= '0;
      filled_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_q       <= set_d;
      way_q       <= way_d;
      rtag_q      <= rtag_d;
      vtag_q      <= vtag_d;
      k_q         <= k_d;
      scan_set_q  <= scan_set_d;
      scan_way_q  <= scan_way_d;
      hit_count_q <= hit_count_d;
      filled_q    <= filled_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    way_d       = way_q;
    rtag_d      = rtag_q;
    vtag_d      = vtag_q;
    k_d         = k_q;
    scan_set_d  = scan_set_q;
    scan_way_d  = scan_way_q;
    hit_count_d = hit_count_q;
    filled_d    = 1'b0;
    cache_set   = '0;
    cache_way   = '0;
    cache_word  = '0;
    load_data   = 1'b0;
    write_tag   = 1'b0;
    set_valid   = 1'b0;
    clear_dirty = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    flushed     = 1'b0;

    case (state_q)
      IDLE: begin
        cache_set = req_set;
        cache_way = victim_way;
        if (halt) begin
          state_d    = FLUSH_SCAN;
          scan_set_d = '0;
          scan_way_d = '0;
        end else if (dmemREN || dmemWEN) begin
          if (hit) begin
            // The hit that completes a fill is the original miss, not a new hit.
            if (!filled_q && hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
          end else begin
            set_d   = req_set;
            way_d   = victim_way;
            rtag_d  = req_tag;
            vtag_d  = frame_tag;
            k_d     = '0;
            state_d = (frame_valid && frame_dirty) ? WB : FILL;
          end
        end
      end

      WB: begin
        cache_set  = set_q;
        cache_way  = way_q;
        cache_word = k_q;
        dWEN       = 1'b1;
        daddr      = blk_addr(vtag_q, set_q, k_q);
        dstore     = rdata;
        if (mem_ready) begin
          if (last_word) begin
            k_d     = '0;
            state_d = FILL;
          end else begin
            k_d = k_q + BW'(1);
          end
        end
      end

      FILL: begin
        cache_set  = set_q;
        cache_way  = way_q;
        cache_word = k_q;
        dREN       = 1'b1;
        daddr      = blk_addr(rtag_q, set_q, k_q);
        load_data  = mem_ready;
        if (mem_ready) begin
          if (last_word) begin
            write_tag   = 1'b1;
            set_valid   = 1'b1;
            clear_dirty = 1'b1;
            k_d         = '0;
            filled_d    = 1'b1;
            state_d     = IDLE;
          end else begin
            k_d = k_q + BW'(1);
          end
        end
      end

      FLUSH_SCAN: begin
        cache_set = scan_set_q;
        cache_way = scan_way_q;
        if (frame_valid && frame_dirty) begin
          k_d     = '0;
          state_d = FLUSH_WB;
        end else if (last_way && last_set) begin
          state_d = COUNT;
        end else if (last_way) begin
          scan_way_d = '0;
          scan_set_d = scan_set_q + SW'(1);
        end else begin
          scan_way_d = scan_way_q + WW'(1);
        end
      end

      // Returns to scan on the same frame; it reads clean next cycle and is skipped.
      FLUSH_WB: begin
        cache_set  = scan_set_q;
        cache_way  = scan_way_q;
        cache_word = k_q;
        dWEN       = 1'b1;
        daddr      = blk_addr(frame_tag, scan_set_q, k_q);
        dstore     = rdata;
        if (mem_ready) begin
          if (last_word) begin
            clear_dirty = 1'b1;
            k_d         = '0;
            state_d     = FLUSH_SCAN;
          end else begin
            k_d = k_q + BW'(1);
          end
        end
      end

      COUNT: begin
        dWEN   = 1'b1;
        daddr  = HIT_ADDR;
        dstore = hit_count_q;
        if (mem_ready) state_d = DONE;
      end

      DONE: flushed = 1'b1;

      default: state_d = IDLE;
    endcase
  end

endmodule
